// File: rtl/sipo_dram_pack.sv
// Serial-in/parallel-out packer feeding the DRAM-side FIFO ahead of the piso_dram serializer.
// Gathers INPUT_SIZE samples LSB-lane-first into OUTPUT_SIZE words, aligned to a frame sync.
module sipo_dram_pack #(
    parameter int INPUT_SIZE  = 32,
    parameter int OUTPUT_SIZE = 288,
    parameter bit WAIT_SYNC   = 1'b1
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   ce,
    input  logic [INPUT_SIZE-1:0]  i_data,
    input  logic                   i_valid,
    input  logic                   i_sync,
    output logic [OUTPUT_SIZE-1:0] o_parallel,
    output logic                   fifo_we,
    input  logic                   fifo_full,
    input  logic                   clr_flags,
    output logic                   o_overflow,
    output logic                   o_misalign,
    output logic [15:0]            o_drop_cnt,
    output logic                   dbg_state
);

    localparam int LANES = OUTPUT_SIZE / INPUT_SIZE;
    localparam int LW = (LANES > 1) ? $clog2(LANES) : 1;
    localparam logic [LW-1:0] LAST_LANE = LW'(LANES - 1);
    localparam logic [LW-1:0] LANE_ONE  = (LANES > 1) ? LW'(1) : '0;

    typedef enum logic {
        ST_WAIT = 1'b0,
        ST_FILL = 1'b1
    } state_t;

    state_t                 state, state_next;
    logic [LW-1:0]          lane, lane_next, store_lane;
    logic [OUTPUT_SIZE-1:0] asm_word, asm_next;
    logic                   accept, sync, store_en, complete, misalign_set, drop, write_en;

    assign accept    = ce & i_valid;
    assign sync      = ce & i_sync;
    assign dbg_state = state;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= WAIT_SYNC ? ST_WAIT : ST_FILL;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        if (state == ST_WAIT && sync) begin
            state_next = ST_FILL;
        end
    end

    // Sync always restarts at lane 0 and takes precedence over completing a word.
    always_comb begin
        store_en     = 1'b0;
        lane_next    = lane;
        complete     = 1'b0;
        misalign_set = 1'b0;
        store_lane   = sync ? '0 : lane;
        case (state)
            ST_WAIT: begin
                if (sync) begin
                    store_en  = accept;
                    lane_next = accept ? LANE_ONE : '0;
                end
            end
            ST_FILL: begin
                if (sync) begin
                    misalign_set = (lane != '0);
                    store_en     = accept;
                    lane_next    = accept ? LANE_ONE : '0;
                end else if (accept) begin
                    store_en = 1'b1;
                    if (lane == LAST_LANE) begin
                        complete  = 1'b1;
                        lane_next = '0;
                    end else begin
                        lane_next = lane + LW'(1);
                    end
                end
            end
            default: begin
                lane_next = '0;
            end
        endcase
    end

    always_comb begin
        asm_next = asm_word;
        if (store_en) begin
            asm_next[store_lane*INPUT_SIZE +: INPUT_SIZE] = i_data;
        end
    end

    assign write_en = complete & ~fifo_full;
    assign drop     = complete & fifo_full;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lane       <= '0;
            asm_word   <= '0;
            o_parallel <= '0;
            fifo_we    <= 1'b0;
        end else begin
            lane     <= lane_next;
            asm_word <= asm_next;
            fifo_we  <= write_en;
            if (write_en) begin
                o_parallel <= asm_next;
            end
        end
    end

    // A drop in the same cycle as a clear leaves a fresh count of one.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            o_overflow <= 1'b0;
            o_misalign <= 1'b0;
            o_drop_cnt <= '0;
        end else begin
            if (drop) begin
                o_overflow <= 1'b1;
                if (clr_flags) begin
                    o_drop_cnt <= 16'd1;
                end else if (o_drop_cnt != 16'hFFFF) begin
                    o_drop_cnt <= o_drop_cnt + 16'd1;
                end
            end else if (clr_flags) begin
                o_overflow <= 1'b0;
                o_drop_cnt <= '0;
            end
            if (misalign_set) begin
                o_misalign <= 1'b1;
            end else if (clr_flags) begin
                o_misalign <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_sipo_dram_pack.sv
// Bench for sipo_dram_pack: directed samples, expected words and write cycles queued by the driver,
// compared by an independent monitor whenever fifo_we is seen.
module tb_sipo_dram_pack;

    localparam int IW = 32;
    localparam int OW = 288;
    localparam int LANES = OW / IW;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          ce = 1'b0;
    logic [IW-1:0] i_data = '0;
    logic          i_valid = 1'b0;
    logic          i_sync = 1'b0;
    logic [OW-1:0] o_parallel;
    logic          fifo_we;
    logic          fifo_full = 1'b0;
    logic          clr_flags = 1'b0;
    logic          o_overflow;
    logic          o_misalign;
    logic [15:0]   o_drop_cnt;
    logic          dbg_state;

    int checks = 0;
    int failures = 0;
    int cyc = 0;

    logic [OW-1:0] exp_q[$];
    int            exp_cyc_q[$];

    sipo_dram_pack #(.INPUT_SIZE(IW), .OUTPUT_SIZE(OW), .WAIT_SYNC(1'b1)) dut (
        .clk(clk), .rst_n(rst_n), .ce(ce), .i_data(i_data), .i_valid(i_valid), .i_sync(i_sync),
        .o_parallel(o_parallel), .fifo_we(fifo_we), .fifo_full(fifo_full), .clr_flags(clr_flags),
        .o_overflow(o_overflow), .o_misalign(o_misalign), .o_drop_cnt(o_drop_cnt),
        .dbg_state(dbg_state)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [OW-1:0] mk(input logic [IW-1:0] base);
        logic [OW-1:0] w;
        w = '0;
        for (int k = 0; k < LANES; k++) w[k*IW +: IW] = base + IW'(k);
        return w;
    endfunction

    task automatic chk(input string name, input logic [OW-1:0] act, input logic [OW-1:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // One clock of stimulus; push=1 queues the word expected one cycle after this edge.
    task automatic drv(input logic c, input logic v, input logic s, input logic f, input logic clr,
                       input logic [IW-1:0] d, input bit push, input logic [OW-1:0] w);
        ce = c; i_valid = v; i_sync = s; fifo_full = f; clr_flags = clr; i_data = d;
        if (push) begin
            exp_q.push_back(w);
            exp_cyc_q.push_back(cyc + 1);
        end
        @(posedge clk);
        #1;
        ce = 1'b1; i_valid = 1'b0; i_sync = 1'b0; fifo_full = 1'b0; clr_flags = 1'b0;
    endtask

    task automatic send(input logic s, input logic [IW-1:0] d);
        drv(1'b1, 1'b1, s, 1'b0, 1'b0, d, 1'b0, '0);
    endtask

    task automatic send_last(input logic [IW-1:0] d, input logic [IW-1:0] base);
        drv(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, d, 1'b1, mk(base));
    endtask

    task automatic idle();
        drv(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, '0, 1'b0, '0);
    endtask

    task automatic clear();
        drv(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, '0, 1'b0, '0);
    endtask

    // Monitor: every write strobe must match the next queued word and its cycle.
    always @(negedge clk) begin
        if (rst_n && fifo_we) begin
            if (exp_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_write: got word %0h at cycle %0d expected no write", o_parallel, cyc);
            end else begin
                logic [OW-1:0] w;
                int            c;
                w = exp_q.pop_front();
                c = exp_cyc_q.pop_front();
                chk("write_word", o_parallel, w);
                chk("write_cycle", OW'(cyc), OW'(c));
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation still running at %0t expected finish", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (3) @(posedge clk);
        #1;
        chk("reset_parallel", o_parallel, '0);
        chk("reset_we", OW'(fifo_we), '0);
        chk("reset_overflow", OW'(o_overflow), '0);
        chk("reset_misalign", OW'(o_misalign), '0);
        chk("reset_drop_cnt", OW'(o_drop_cnt), '0);
        chk("reset_state", OW'(dbg_state), '0);
        rst_n = 1'b1;
        ce = 1'b1;
        idle();

        // Samples before the first sync are discarded.
        for (int i = 0; i < 5; i++) send(1'b0, 32'hA0 + 32'(i));
        chk("wait_state", OW'(dbg_state), '0);

        // Sync word 0x1..0x9, lane 0 in LSBs.
        send(1'b1, 32'h1);
        for (int i = 2; i < 9; i++) send(1'b0, 32'(i));
        send_last(32'h9, 32'h1);
        idle();
        chk("fill_state", OW'(dbg_state), 1);
        chk("word1_parallel_hold", o_parallel, mk(32'h1));

        // 27 back-to-back samples, sync on lane 0 is a no-op.
        for (int i = 0; i < 27; i++) begin
            if (i % 9 == 8) send_last(32'h100 + 32'(i), 32'h100 + 32'(i - 8));
            else send(i == 0, 32'h100 + 32'(i));
        end
        idle();
        chk("stream_no_misalign", OW'(o_misalign), '0);

        // FIFO full on completion of the middle word.
        for (int i = 0; i < 27; i++) begin
            if (i == 8 || i == 26) send_last(32'h200 + 32'(i), 32'h200 + 32'(i - 8));
            else drv(1'b1, 1'b1, 1'b0, i == 17, 1'b0, 32'h200 + 32'(i), 1'b0, '0);
        end
        idle();
        chk("drop_cnt_one", OW'(o_drop_cnt), 1);
        chk("overflow_set", OW'(o_overflow), 1);
        // Drop and clear together: the drop wins with a fresh count.
        for (int i = 0; i < 9; i++) drv(1'b1, 1'b1, 1'b0, i == 8, i == 8, 32'h280 + 32'(i), 1'b0, '0);
        idle();
        chk("clr_drop_cnt", OW'(o_drop_cnt), 1);
        chk("clr_drop_overflow", OW'(o_overflow), 1);
        clear();
        chk("cleared_drop_cnt", OW'(o_drop_cnt), '0);
        chk("cleared_overflow", OW'(o_overflow), '0);

        // Early sync after 4 samples, then ce toggling with valid held high.
        for (int i = 0; i < 4; i++) send(1'b0, 32'h300 + 32'(i));
        send(1'b1, 32'h310);
        chk("misalign_set", OW'(o_misalign), 1);
        for (int k = 1; k < 9; k++) begin
            drv(1'b0, 1'b1, k == 4, 1'b0, 1'b0, 32'hDEAD, 1'b0, '0);
            if (k == 8) send_last(32'h318, 32'h310);
            else send(1'b0, 32'h310 + 32'(k));
        end
        idle();
        chk("misalign_sticky", OW'(o_misalign), 1);
        clear();
        chk("misalign_cleared", OW'(o_misalign), '0);

        // Asynchronous reset with five lanes filled.
        for (int i = 0; i < 5; i++) send(1'b0, 32'h500 + 32'(i));
        #2;
        rst_n = 1'b0;
        #1;
        chk("async_parallel", o_parallel, '0);
        chk("async_we", OW'(fifo_we), '0);
        chk("async_state", OW'(dbg_state), '0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        for (int i = 0; i < 4; i++) send(1'b0, 32'h600 + 32'(i));
        send(1'b1, 32'h700);
        for (int i = 1; i < 8; i++) send(1'b0, 32'h700 + 32'(i));
        send_last(32'h708, 32'h700);
        idle();
        chk("restart_state", OW'(dbg_state), 1);

        for (int i = 0; i < 20 && exp_q.size() != 0; i++) idle();
        checks++;
        if (exp_q.size() != 0) begin
            failures++;
            $display("FAIL missing_writes: got %0d words still pending expected 0", exp_q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
